// File: rtl/rtl_seq_mul.sv
// Multi-cycle unsigned shift-add multiplier: one multiplier bit retired per clock.
// Optional macro RTL_SEQ_MUL_EARLY_DONE_EN finishes as soon as the remaining multiplier bits are zero.
module rtl_seq_mul #(
  parameter int SIZE1 = 8,
  parameter int SIZE2 = 8,
  parameter int AREA  = SIZE1 * 3,
  parameter int DELAY = SIZE2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [SIZE1-1:0]       in1,
  input  logic [SIZE2-1:0]       in2,
  output logic                   busy,
  output logic                   done,
  output logic [SIZE1+SIZE2-1:0] out
);
  localparam int PW = SIZE1 + SIZE2;
  localparam int CW = $clog2(SIZE2 + 1);

  // AREA and DELAY are mapper cost figures; they only need to be sane.
  if (SIZE1 < 1 || SIZE2 < 1 || AREA < 0 || DELAY < 0) begin : g_bad_param
    $error("rtl_seq_mul: invalid parameter set");
  end

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t          state, state_n;
  logic [PW-1:0]   a, acc, acc_n;
  logic [SIZE2-1:0] b, b_n;
  logic [CW-1:0]   cnt, cnt_n;
  logic            last, accept;

  always_comb begin
    acc_n  = acc + (b[0] ? a : '0);
    b_n    = b >> 1;
    cnt_n  = cnt + 1'b1;
`ifdef RTL_SEQ_MUL_EARLY_DONE_EN
    last   = (cnt_n == CW'(SIZE2)) || (b_n == '0);
`else
    last   = (cnt_n == CW'(SIZE2));
`endif
    accept = start && (state != CALC);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (start) state_n = CALC;
      CALC:    if (last)  state_n = DONE;
      DONE:    state_n = start ? CALC : IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Product register only updates on the final CALC edge, so partial sums never leak.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a   <= '0;
      b   <= '0;
      acc <= '0;
      cnt <= '0;
      out <= '0;
    end else if (accept) begin
      a   <= PW'(in1);
      b   <= in2;
      acc <= '0;
      cnt <= '0;
    end else if (state == CALC) begin
      a   <= a << 1;
      b   <= b_n;
      acc <= acc_n;
      cnt <= cnt_n;
      if (last) out <= acc_n;
    end
  end

  assign busy = (state == CALC);
  assign done = (state == DONE);

endmodule

// File: tb/tb_rtl_seq_mul.sv
// Directed bench for rtl_seq_mul (default 8x8); inputs driven and outputs sampled on negedge.
module tb_rtl_seq_mul;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  in1 = '0;
  logic [7:0]  in2 = '0;
  logic        busy, done;
  logic [15:0] out;
  int          checks = 0;
  int          errors = 0;

  rtl_seq_mul #(.SIZE1(8), .SIZE2(8)) dut (
    .clk(clk), .reset(reset), .start(start), .in1(in1), .in2(in2),
    .busy(busy), .done(done), .out(out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Number of CALC cycles for a given multiplier value.
  function automatic int lat(input int b);
    int l;
    l = 8;
`ifdef RTL_SEQ_MUL_EARLY_DONE_EN
    l = 1;
    for (int i = 0; i < 8; i++) if (b[i]) l = i + 1;
`endif
    return l;
  endfunction

  // Called at a negedge; the following posedge is the accepting edge k.
  task automatic start_op(input logic [7:0] a, input logic [7:0] b);
    start = 1'b1; in1 = a; in2 = b;
    @(negedge clk);
    start = 1'b0; in1 = ~a; in2 = ~b;
    chk("busy_after_start", {31'b0, busy}, 1);
    chk("done_after_start", {31'b0, done}, 0);
  endtask

  // Walks the remaining CALC cycles, optionally pulsing start at step pulse_at, then checks done.
  task automatic wait_done(input int l, input logic [15:0] exp, input int pulse_at, input string tag);
    for (int i = 0; i < l - 1; i++) begin
      @(negedge clk);
      chk({tag, "_busy"}, {31'b0, busy}, 1);
      chk({tag, "_nodone"}, {31'b0, done}, 0);
      start = (i == pulse_at);
      in1 = 8'd1; in2 = 8'd1;
    end
    @(negedge clk);
    start = 1'b0;
    chk({tag, "_done"}, {31'b0, done}, 1);
    chk({tag, "_busy_low"}, {31'b0, busy}, 0);
    chk({tag, "_out"}, {16'b0, out}, {16'b0, exp});
  endtask

  task automatic idle_chk(input logic [15:0] exp, input string tag);
    @(negedge clk);
    chk({tag, "_idle_done"}, {31'b0, done}, 0);
    chk({tag, "_idle_busy"}, {31'b0, busy}, 0);
    chk({tag, "_hold"}, {16'b0, out}, {16'b0, exp});
  endtask

  initial begin
    #1;
    chk("rst_busy", {31'b0, busy}, 0);
    chk("rst_done", {31'b0, done}, 0);
    chk("rst_out", {16'b0, out}, 0);
    @(negedge clk);
    reset = 1'b0;
    idle_chk(16'd0, "post_rst");

    start_op(8'd13, 8'd11);
    wait_done(lat(11), 16'd143, -1, "m13x11");
    idle_chk(16'd143, "m13x11");

    start_op(8'd255, 8'd255);
    wait_done(lat(255), 16'hFE01, -1, "m255x255");
    idle_chk(16'hFE01, "m255x255");

    start_op(8'd200, 8'd0);
    wait_done(lat(0), 16'd0, -1, "m200x0");
    idle_chk(16'd0, "m200x0");

    // Back-to-back: start is raised in the DONE cycle of the first product.
    start_op(8'd7, 8'd9);
    wait_done(lat(9), 16'd63, -1, "b2b_first");
    start_op(8'd3, 8'd5);
    wait_done(lat(5), 16'd15, -1, "b2b_second");
    idle_chk(16'd15, "b2b");

    // start pulse with 1*1 in the middle of 10*10 must be ignored.
    start_op(8'd10, 8'd10);
    wait_done(lat(10), 16'd100, 1, "m10x10");
    for (int i = 0; i < 4; i++) idle_chk(16'd100, "single_done");

    // Asynchronous reset between clock edges mid-CALC.
    start_op(8'd50, 8'd50);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("arst_busy", {31'b0, busy}, 0);
    chk("arst_done", {31'b0, done}, 0);
    chk("arst_out", {16'b0, out}, 0);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 12; i++) idle_chk(16'd0, "arst_quiet");

    start_op(8'd6, 8'd7);
    wait_done(lat(7), 16'd42, -1, "m6x7");
    idle_chk(16'd42, "m6x7");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
